memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: memory cycles per access; legal range 1..15.
REQ-002 Parameter WORD_SIZE, default 16: data and address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  fetch-stage read request; held with i_addr until i_ready.
REQ-006 i_addr  input  16  fetch address.
REQ-007 i_cancel  input  1  fetch-stage flush; aborts a pending fetch.
REQ-008 i_data  output  16  fetched instruction word.
REQ-009 i_ready  output  1  fetch completion strobe.
REQ-010 d_read  input  1  MEM-stage load request; held with d_addr until d_ready.
REQ-011 d_write  input  1  MEM-stage store request; held with d_addr and d_wdata until d_ready.
REQ-012 d_addr  input  16  data address.
REQ-013 d_wdata  input  16  store data.
REQ-014 d_rdata  output  16  load data.
REQ-015 d_ready  output  1  data completion strobe.
REQ-016 mem_read  output  1  read enable to the single-port unified memory.
REQ-017 mem_write  output  1  write enable to the memory.
REQ-018 mem_addr  output  16  memory address.
REQ-019 mem_wdata  output  16  memory write data.
REQ-020 mem_rdata  input  16  memory read data, valid in the final access cycle.
REQ-021 busy  output  1  high whenever the state is not IDLE.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, IACC and DACC.
REQ-023 In IDLE, a request SHALL be sampled at the clock edge; (d_read|d_write) goes to DACC, else i_req&~i_cancel goes to IACC, else the FSM stays in IDLE; data has priority over fetch.
REQ-024 On entry to an access state, the address, wdata and read/write type SHALL be latched, and the 4-bit counter SHALL load LATENCY-1.
REQ-025 In an access state, mem_addr, mem_wdata, mem_read and mem_write SHALL be driven from the latched registers only, and SHALL stay constant for all LATENCY cycles.
REQ-026 Outside access states, mem_read=0 and mem_write=0; mem_addr and mem_wdata SHALL hold their last values.
REQ-027 The counter SHALL decrement each cycle while nonzero; the cycle with counter=0 is the final access cycle.
REQ-028 i_ready SHALL be combinational: high iff the state is IACC, the counter is 0 and i_cancel=0; d_ready SHALL be high iff the state is DACC and the counter is 0.
REQ-029 i_data SHALL equal mem_rdata while i_ready=1, then hold the captured value until the next i_ready; d_rdata SHALL behave the same way for a DACC read.
REQ-030 On a DACC write, d_rdata SHALL be unchanged.
REQ-031 At the completion edge, the just-served port's request SHALL be masked.
REQ-032 After IACC completes, the FSM SHALL go to DACC if (d_read|d_write), else to IDLE.
REQ-033 After DACC completes, the FSM SHALL go to IACC if i_req&~i_cancel, else to IDLE.
REQ-034 Back-to-back accesses SHALL have no idle bubble between them.
REQ-035 i_cancel=1 in IACC SHALL suppress i_ready, and the FSM SHALL go to IDLE at the next edge with i_data unchanged.
REQ-036 i_cancel SHALL have no effect in DACC.
REQ-037 d_read and d_write both high SHALL be treated as a write.
REQ-038 A request change mid-access SHALL be ignored until the next arbitration point.
REQ-039 With LATENCY=1, every access SHALL complete in its entry cycle+1, i.e. one cycle in the access state.

Reset
REQ-040 On reset=1, the FSM SHALL go immediately to IDLE and the counter to 0.
REQ-041 On reset=1, mem_read, mem_write, i_ready, d_ready and busy SHALL be 0, and mem_addr, mem_wdata, i_data and d_rdata SHALL be 16'h0000; this holds asynchronously, including mid-access.
REQ-042 An access interrupted by reset SHALL produce no ready strobe; after reset deasserts, arbitration SHALL restart from IDLE.

Verification
REQ-043 LATENCY=2, i_req=1, i_addr=16'h0010, mem model returns 16'h6A01 -> mem_read high 2 cycles at 16'h0010; i_ready one cycle in the 2nd; i_data=16'h6A01 and held afterwards.
REQ-044 i_req and d_read both asserted in IDLE, d_addr=16'h0100 -> DACC first, d_ready after 2 cycles, then IACC with no bubble, i_ready 2 cycles later.
REQ-045 d_write=1, d_addr=16'h0020, d_wdata=16'hBEEF -> mem_write high 2 cycles with mem_wdata=16'hBEEF; d_ready pulses once; d_rdata unchanged.
REQ-046 i_cancel pulsed in the 1st IACC cycle -> no i_ready, FSM returns to IDLE, i_data keeps its old value.
REQ-047 reset asserted in the 2nd DACC cycle -> same-cycle mem_write=0, busy=0, no d_ready; after deassertion, a held d_read restarts a full LATENCY access.
REQ-048 LATENCY=1 with continuous i_req and d_read -> strict alternation D,I,D,I..., one ready strobe per cycle.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates fetch and data ports onto a single-port memory with fixed access latency.
module memory_arbiter #(
    parameter int LATENCY   = 2,
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic                 i_cancel,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
    state_t               state;
    logic [3:0]           cnt;
    logic                 wr;
    logic [WORD_SIZE-1:0] addr_q, wdata_q, i_data_q, d_data_q;
    logic                 d_req, i_go;
    assign d_req     = d_read | d_write;
    assign i_go      = i_req & ~i_cancel;
    assign busy      = state != IDLE;
    assign mem_read  = busy & ~wr;
    assign mem_write = busy & wr;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ready   = (state == IACC) && (cnt == 4'd0) && !i_cancel;
    assign d_ready   = (state == DACC) && (cnt == 4'd0);
    assign i_data    = i_ready ? mem_rdata : i_data_q;
    assign d_rdata   = (d_ready && !wr) ? mem_rdata : d_data_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            wr       <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            if (i_ready) i_data_q <= mem_rdata;
            if (d_ready && !wr) d_data_q <= mem_rdata;
            if (state == IACC && i_cancel) begin
                state <= IDLE;
                cnt   <= 4'd0;
            end else if (state != IDLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else if (d_req && state != DACC) begin
                state   <= DACC;
                cnt     <= 4'(LATENCY - 1);
                wr      <= d_write;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
            end else if (i_go && state != IACC) begin
                state  <= IACC;
                cnt    <= 4'(LATENCY - 1);
                wr     <= 1'b0;
                addr_q <= i_addr;
            end else begin
                state <= IDLE;
                cnt   <= 4'd0;
                wr    <= 1'b0;
            end
        end
    end
endmodule
